// File: rtl/multi_enable_gen.sv
// Multi-channel programmable clock-enable generator: per-channel divide, periodic or
// one-shot mode, immediate or wrap-deferred reconfiguration, and global phase sync.
module multi_enable_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_BITS    = 24,
    parameter int DEFAULT_DIV = 100000,
    parameter bit RESET_RUN   = 1'b1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_BITS-1:0] cfg_div,
    input  logic                cfg_oneshot,
    input  logic                cfg_run,
    input  logic                cfg_defer,
    input  logic                sync,
    output logic [NUM_CH-1:0]   out_en,
    output logic [NUM_CH-1:0]   ch_active
);

    initial begin
        if (NUM_CH < 1 || DEFAULT_DIV < 2 ||
            (DIV_BITS < 31 && DEFAULT_DIV >= (1 << DIV_BITS)))
            $finish;
    end

    logic [NUM_CH-1:0][DIV_BITS-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][DIV_BITS-1:0] div_q, div_d;
    logic [NUM_CH-1:0][DIV_BITS-1:0] sh_div_q, sh_div_d;
    logic [NUM_CH-1:0] oneshot_q, oneshot_d, run_q, run_d;
    logic [NUM_CH-1:0] sh_oneshot_q, sh_oneshot_d, sh_run_q, sh_run_d;
    logic [NUM_CH-1:0] pending_q, pending_d, out_en_q, out_en_d;
    logic [NUM_CH-1:0] acc, wrap;
    logic [DIV_BITS-1:0] cfg_div_eff;

    // Divides below 2 are stored already clamped so the wrap compare stays simple.
    assign cfg_div_eff = (cfg_div < DIV_BITS'(2)) ? DIV_BITS'(2) : cfg_div;

    // NOTE: every comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pending_q[i];
    end

    always_comb begin
        acc  = '0;
        wrap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc[i]  = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
            wrap[i] = run_q[i] && (cnt_q[i] == div_q[i] - DIV_BITS'(1));
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        div_d        = div_q;
        oneshot_d    = oneshot_q;
        run_d        = run_q;
        sh_div_d     = sh_div_q;
        sh_oneshot_d = sh_oneshot_q;
        sh_run_d     = sh_run_q;
        pending_d    = pending_q;
        out_en_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc[i] && !(cfg_defer && run_q[i])) begin
                div_d[i]     = cfg_div_eff;
                oneshot_d[i] = cfg_oneshot;
                run_d[i]     = cfg_run;
                cnt_d[i]     = '0;
            end else begin
                if (acc[i]) begin
                    sh_div_d[i]     = cfg_div_eff;
                    sh_oneshot_d[i] = cfg_oneshot;
                    sh_run_d[i]     = cfg_run;
                    pending_d[i]    = 1'b1;
                end
                if (!run_q[i] || sync) begin
                    cnt_d[i] = '0;
                end else if (wrap[i]) begin
                    cnt_d[i]    = '0;
                    out_en_d[i] = 1'b1;
                    // A deferred write landing on a wrap edge applies there, so pending never strands.
                    if (pending_q[i] || acc[i]) begin
                        div_d[i]     = acc[i] ? cfg_div_eff : sh_div_q[i];
                        oneshot_d[i] = acc[i] ? cfg_oneshot : sh_oneshot_q[i];
                        run_d[i]     = acc[i] ? cfg_run     : sh_run_q[i];
                        pending_d[i] = 1'b0;
                    end else if (oneshot_q[i]) begin
                        run_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_BITS'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                div_q[i]    <= DIV_BITS'(DEFAULT_DIV);
                sh_div_q[i] <= DIV_BITS'(DEFAULT_DIV);
            end
            oneshot_q    <= '0;
            run_q        <= {NUM_CH{RESET_RUN}};
            sh_oneshot_q <= '0;
            sh_run_q     <= '0;
            pending_q    <= '0;
            out_en_q     <= '0;
        end else begin
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            sh_div_q     <= sh_div_d;
            oneshot_q    <= oneshot_d;
            run_q        <= run_d;
            sh_oneshot_q <= sh_oneshot_d;
            sh_run_q     <= sh_run_d;
            pending_q    <= pending_d;
            out_en_q     <= out_en_d;
        end
    end

    assign out_en    = out_en_q;
    assign ch_active = run_q;

endmodule

// File: tb/tb_multi_enable_gen.sv
// Directed bench for multi_enable_gen: expected strobe edges are queued per channel as
// stimulus is issued and matched against out_en on every falling clock edge.
module tb_multi_enable_gen;

    localparam int NUM_CH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_oneshot;
    logic       cfg_run;
    logic       cfg_defer;
    logic       sync;
    logic [3:0] out_en;
    logic [3:0] ch_active;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_q[NUM_CH][$];
    bit mon_hit;

    multi_enable_gen #(
        .NUM_CH(NUM_CH), .DIV_BITS(8), .DEFAULT_DIV(10), .RESET_RUN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .cfg_run(cfg_run),
        .cfg_defer(cfg_defer), .sync(sync), .out_en(out_en), .ch_active(ch_active)
    );

    always #5 clk = ~clk;

    // Edge index since reset release: a strobe issued at edge E is seen at the negedge with cyc == E.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            mon_hit = 1'b0;
            if (exp_q[c].size() > 0)
                if (exp_q[c][0] == cyc) mon_hit = 1'b1;
            if (out_en[c] || mon_hit) begin
                checks++;
                assert (out_en[c] === mon_hit) else begin
                    errors++;
                    $error("FAIL strobe ch%0d edge %0d: out_en=%b expected %b", c, cyc, out_en[c], mon_hit);
                end
                if (mon_hit) void'(exp_q[c].pop_front());
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        int n = 0;
        while (cyc < c && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_edge", cyc, c);
    endtask

    task automatic push_seq(input int ch, input int first, input int period, input int n);
        for (int k = 0; k < n; k++) exp_q[ch].push_back(first + k * period);
    endtask

    task automatic cfg_write(input int ch, input int div, input bit os, input bit run, input bit defer);
        cfg_valid   = 1'b1;
        cfg_ch      = 2'(ch);
        cfg_div     = 8'(div);
        cfg_oneshot = os;
        cfg_run     = run;
        cfg_defer   = defer;
        #1 check("cfg_ready_at_write", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        cfg_oneshot = 1'b0; cfg_run = 1'b0; cfg_defer = 1'b0; sync = 1'b0;
        @(negedge clk);
        #1;
        check("reset_out_en", out_en, 4'h0);
        check("reset_ch_active", ch_active, 4'hF);
        check("reset_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        push_seq(0, 10, 10, 5); push_seq(1, 10, 10, 2);
        push_seq(2, 10, 10, 3); push_seq(3, 10, 10, 5);

        // Immediate reprogram of ch1 mid-period, accepted at edge 24.
        wait_until(23);
        push_seq(1, 29, 5, 5);
        cfg_write(1, 5, 1'b0, 1'b1, 1'b0);

        // One-shot on ch2 accepted at edge 35: single strobe at edge 42.
        wait_until(34);
        push_seq(2, 42, 7, 1);
        cfg_write(2, 7, 1'b1, 1'b1, 1'b0);
        wait_until(41);
        check("oneshot_active_before", ch_active, 4'hF);
        wait_until(42);
        #1 check("oneshot_active_after", ch_active, 4'hB);

        // Deferred write on ch0 accepted at edge 45, applied at its wrap on edge 50.
        wait_until(44);
        push_seq(0, 54, 4, 3);
        cfg_write(0, 4, 1'b0, 1'b1, 1'b1);
        #1 check("defer_ready_low", cfg_ready, 0);
        cfg_ch = 2'd1;
        #1 check("defer_ready_other_ch", cfg_ready, 1);
        cfg_ch = 2'd0;
        wait_until(49);
        #1 check("defer_ready_still_low", cfg_ready, 0);
        wait_until(50);
        #1 check("defer_ready_back", cfg_ready, 1);

        // div=0 on ch3 and div=1 on ch1; ch1's write lands on its own wrap edge 54.
        wait_until(52);
        push_seq(3, 55, 2, 4);
        cfg_write(3, 0, 1'b0, 1'b1, 1'b0);
        push_seq(1, 56, 2, 4);
        cfg_write(1, 1, 1'b0, 1'b1, 1'b0);

        // sync at edge 63 coincides with ch3's wrap.
        wait_until(62);
        push_seq(0, 67, 4, 2);
        push_seq(1, 65, 2, 5); push_seq(1, 77, 2, 1);
        push_seq(3, 65, 2, 5); push_seq(3, 77, 2, 1);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;

        // Deferred write on ch0 at edge 73, then sync on its wrap edge 75 keeps it pending.
        wait_until(72);
        cfg_write(0, 9, 1'b0, 1'b1, 1'b1);
        #1 check("defer2_ready_low", cfg_ready, 0);
        wait_until(74);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        #1 check("sync_keeps_pending", cfg_ready, 0);

        // Asynchronous reset while strobes are high and a write is pending.
        wait_until(77);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out_en", out_en, 4'h0);
        check("async_reset_ch_active", ch_active, 4'hF);
        check("async_reset_pending", cfg_ready, 1);
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NUM_CH; c++) push_seq(c, 10, 10, 2);
        wait_until(22);
        #1;
        for (int c = 0; c < NUM_CH; c++) check($sformatf("leftover_ch%0d", c), exp_q[c].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
